// File: rtl/t_count_ctrl.sv
// Sequencer for a falling-edge T-flop down-counter bank: loads a start value by
// toggle-difference, counts to zero with pause/abort, and pulses done on completion.
module t_count_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t_vec,
    output logic             bank_clear,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] load_reg_q, load_reg_d;
    logic [WIDTH-1:0] dec_vec;
    logic             zero_run;
    logic             q_zero;
    logic             bank_clear_q, busy_q, done_q;

    assign q_zero = (q_in == '0);

    // Decrement toggle pattern: bit i flips when every lower bit is zero.
    always_comb begin
        dec_vec  = '0;
        zero_run = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dec_vec[i] = zero_run;
            zero_run   = zero_run & ~q_in[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        load_reg_d = load_reg_q;
        if (abort) begin
            state_d = S_CLR;
        end else begin
            unique case (state_q)
                S_CLR:  state_d = S_IDLE;
                S_IDLE: begin
                    if (start) begin
                        load_reg_d = load_val;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: state_d = (load_reg_q != '0) ? S_RUN : S_DONE;
                S_RUN:  state_d = q_zero ? S_DONE : S_RUN;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_CLR;
            endcase
        end
    end

    // Bank toggle inputs must settle before the falling edge.
    always_comb begin
        t_vec = '0;
        unique case (state_q)
            S_LOAD: t_vec = q_in ^ load_reg_q;
            S_RUN:  t_vec = (pause || q_zero) ? '0 : dec_vec;
            default: t_vec = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= S_CLR;
            load_reg_q   <= '0;
            bank_clear_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_reg_q   <= load_reg_d;
            bank_clear_q <= (state_d == S_CLR);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign bank_clear = bank_clear_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
